mem_stage_lsu: RTL and testbench

Memory-stage load/store unit for the 5-stage pipeline. It sits between the EX/MEM and MEM/WB pipeline registers and drives the MEM/WB inputs. It runs a request/acknowledge transaction to data memory, handles byte/half/word lane selection and load sign/zero extension, and stalls the upstream pipeline while an access is outstanding. Non-memory instructions pass through with zero latency.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/load_extend.sv | 34 +++
 rtl/mem_stage_lsu.sv | 181 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants, state type and byte-lane helpers for the memory-stage LSU.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte enables for a store; half stores only ever land on lane 0 or lane 2.
  function automatic logic [3:0] wstrb_encode(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] s;
    case (f3)
      F3_SB:   s = 4'b0001 << a;
      F3_SH:   s = 4'b0011 << {a[1], 1'b0};
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a load word and sign- or zero-extends it.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {24'h0, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_data = {16'h0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data-memory handshake with timeout,
// lane steering, load extension and upstream stall generation.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  rd_addr_in,
  input  logic        RegWrite_in,
  input  logic        MemToReg_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [2:0]  funct3_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_read_data_out,
  output logic [4:0]  rd_addr_out,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic        mem_stall,
  output logic        access_err
);

  localparam int CNT_W = $clog2(TIMEOUT);

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store)
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tout;
  logic             r_regwrite;
  logic             r_memtoreg;
  logic [31:0]      r_alu;
  logic [31:0]      r_rdata;
  logic [4:0]       r_rd;
  logic [2:0]       r_funct3;

  logic             w_mem_op;
  logic             w_legal;
  logic             w_start;
  logic             w_illegal;
  logic [31:0]      w_ext;

  // MemWrite wins when both MemRead and MemWrite are set.
  assign w_mem_op  = ex_valid & (MemRead_in | MemWrite_in);
  assign w_legal   = f3_legal(MemWrite_in, funct3_in) & ~misaligned(funct3_in, alu_result_in[1:0]);
  assign w_start   = (r_state == IDLE) & w_mem_op & w_legal;
  assign w_illegal = (r_state == IDLE) & w_mem_op & ~w_legal;

  load_extend u_load_extend (
    .i_rdata   (dmem_rdata),
    .i_addr_lo (r_alu[1:0]),
    .i_funct3  (r_funct3),
    .o_data    (w_ext)
  );

  // Control and registered memory-port state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_tout     <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state    <= REQ;
            r_cnt      <= '0;
            r_tout     <= 1'b0;
            r_regwrite <= RegWrite_in;
            r_memtoreg <= MemToReg_in;
            dmem_req   <= 1'b1;
            dmem_we    <= MemWrite_in;
            dmem_addr  <= {alu_result_in[31:2], 2'b00};
            dmem_wdata <= lane_wdata(funct3_in, store_data_in);
            dmem_wstrb <= MemWrite_in ? wstrb_encode(funct3_in, alu_result_in[1:0]) : 4'b0000;
          end
        end
        REQ: begin
          if (dmem_ack) begin
            r_state  <= DONE;
            dmem_req <= 1'b0;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state  <= DONE;
            r_tout   <= 1'b1;
            dmem_req <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Datapath latches, no reset needed: only observed from REQ/DONE
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_alu    <= alu_result_in;
      r_rd     <= rd_addr_in;
      r_funct3 <= funct3_in;
    end
    if ((r_state == REQ) && dmem_ack)
      r_rdata <= dmem_we ? 32'h0 : w_ext;
  end

  always_comb begin
    alu_result_out    = '0;
    mem_read_data_out = '0;
    rd_addr_out       = '0;
    RegWrite_out      = 1'b0;
    MemToReg_out      = 1'b0;
    mem_stall         = 1'b0;
    access_err        = 1'b0;
    case (r_state)
      IDLE: begin
        alu_result_out = alu_result_in;
        rd_addr_out    = rd_addr_in;
        RegWrite_out   = RegWrite_in & ~w_illegal & ~w_start;
        MemToReg_out   = MemToReg_in;
        mem_stall      = w_start;
        access_err     = w_illegal;
      end
      REQ: begin
        alu_result_out = r_alu;
        rd_addr_out    = r_rd;
        MemToReg_out   = r_memtoreg;
        mem_stall      = 1'b1;
      end
      DONE: begin
        alu_result_out    = r_alu;
        rd_addr_out       = r_rd;
        MemToReg_out      = r_memtoreg;
        RegWrite_out      = r_regwrite & ~r_tout;
        mem_read_data_out = r_tout ? 32'h0 : r_rdata;
        access_err        = r_tout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases followed by random
// instructions compared against a transaction-level reference model.
module tb_mem_stage_lsu;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] alu_result_in, store_data_in;
  logic [4:0]  rd_addr_in;
  logic        RegWrite_in, MemToReg_in, MemRead_in, MemWrite_in;
  logic [2:0]  funct3_in;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] alu_result_out, mem_read_data_out;
  logic [4:0]  rd_addr_out;
  logic        RegWrite_out, MemToReg_out, mem_stall, access_err;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .rd_addr_in(rd_addr_in), .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .funct3_in(funct3_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .alu_result_out(alu_result_out),
    .mem_read_data_out(mem_read_data_out), .rd_addr_out(rd_addr_out),
    .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
    .mem_stall(mem_stall), .access_err(access_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on access size and byte offset.
  function automatic bit m_legal(input bit mw, input logic [2:0] f3, input logic [31:0] a);
    int unsigned sz;
    bit ok;
    if (mw) ok = (f3 <= 3'd2);
    else    ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    sz = 1 << f3[1:0];
    return ok && ((a % sz) == 0);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3[1:0] == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_wstrb(input logic [2:0] f3, input logic [31:0] a);
    int unsigned off = a % 4;
    if (f3[1:0] == 0) return 32'(1 << off);
    if (f3[1:0] == 1) return 32'(3 << off);
    return 32'hF;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int unsigned off = a % 4;
    logic [31:0] v;
    if (f3[1:0] == 0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (!f3[2] && v >= 32'h80) v = v - 32'h100;
    end else if (f3[1:0] == 1) begin
      v = (w >> (8 * off)) & 32'hFFFF;
      if (!f3[2] && v >= 32'h8000) v = v - 32'h1_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic set_in(input bit v, input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                        input bit rw, input bit m2r, input bit mr, input bit mw, input logic [2:0] f3);
    ex_valid = v; alu_result_in = a; store_data_in = sd; rd_addr_in = rd;
    RegWrite_in = rw; MemToReg_in = m2r; MemRead_in = mr; MemWrite_in = mw; funct3_in = f3;
  endtask

  task automatic run_alu(input string tag, input bit v, input logic [31:0] a, input logic [4:0] rd,
                         input bit rw, input bit m2r, input bit mr, input bit mw);
    set_in(v, a, $urandom, rd, rw, m2r, mr, mw, 3'($urandom));
    #1;
    chk({tag, " alu_out"}, alu_result_out, a);
    chk({tag, " rd"}, 32'(rd_addr_out), 32'(rd));
    chk({tag, " regwrite"}, 32'(RegWrite_out), 32'(rw));
    chk({tag, " memtoreg"}, 32'(MemToReg_out), 32'(m2r));
    chk({tag, " rdata0"}, mem_read_data_out, 32'h0);
    chk({tag, " stall"}, 32'(mem_stall), 32'h0);
    chk({tag, " err"}, 32'(access_err), 32'h0);
    chk({tag, " noreq"}, 32'(dmem_req), 32'h0);
    @(negedge clk);
  endtask

  task automatic run_bad(input string tag, input logic [31:0] a, input bit mr, input bit mw, input logic [2:0] f3);
    set_in(1'b1, a, $urandom, 5'($urandom), 1'b1, 1'($urandom), mr, mw, f3);
    #1;
    chk({tag, " err"}, 32'(access_err), 32'h1);
    chk({tag, " stall"}, 32'(mem_stall), 32'h0);
    chk({tag, " regwrite"}, 32'(RegWrite_out), 32'h0);
    chk({tag, " noreq"}, 32'(dmem_req), 32'h0);
    @(negedge clk);
    set_in(1'b0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'h0);
    #1;
    chk({tag, " noreq_after"}, 32'(dmem_req), 32'h0);
    chk({tag, " err_1cyc"}, 32'(access_err), 32'h0);
    @(negedge clk);
  endtask

  // ack_at = REQ cycle (1-based) carrying the ack; 0 means never acked.
  task automatic run_mem(input string tag, input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                         input bit rw, input bit m2r, input bit mr, input bit mw, input logic [2:0] f3,
                         input logic [31:0] rdata, input int ack_at);
    int stalls = 0;
    int reqs = 0;
    bit tout = (ack_at < 1) || (ack_at > TIMEOUT);
    set_in(1'b1, a, sd, rd, rw, m2r, mr, mw, f3);
    dmem_ack = 1'b0; dmem_rdata = $urandom;
    #1;
    chk({tag, " idle_stall"}, 32'(mem_stall), 32'h1);
    chk({tag, " idle_err"}, 32'(access_err), 32'h0);
    stalls += int'(mem_stall);
    @(negedge clk);
    for (int k = 1; k <= TIMEOUT; k++) begin
      dmem_ack = (k == ack_at);
      dmem_rdata = (k == ack_at) ? rdata : $urandom;
      #1;
      stalls += int'(mem_stall);
      reqs += int'(dmem_req);
      chk({tag, " addr"}, dmem_addr, a & 32'hFFFF_FFFC);
      chk({tag, " we"}, 32'(dmem_we), 32'(mw));
      chk({tag, " wstrb"}, 32'(dmem_wstrb), mw ? m_wstrb(f3, a) : 32'h0);
      if (mw) chk({tag, " wdata"}, dmem_wdata, m_wdata(f3, sd));
      @(negedge clk);
      if (k == ack_at) break;
    end
    dmem_ack = 1'b1;
    dmem_rdata = $urandom;
    #1;
    chk({tag, " req_cycles"}, 32'(reqs), tout ? 32'(TIMEOUT) : 32'(ack_at));
    chk({tag, " stall_cycles"}, 32'(stalls), tout ? 32'(TIMEOUT + 1) : 32'(ack_at + 1));
    chk({tag, " done_stall"}, 32'(mem_stall), 32'h0);
    chk({tag, " done_req"}, 32'(dmem_req), 32'h0);
    chk({tag, " done_err"}, 32'(access_err), 32'(tout));
    chk({tag, " done_regwrite"}, 32'(RegWrite_out), tout ? 32'h0 : 32'(rw));
    chk({tag, " done_rd"}, 32'(rd_addr_out), 32'(rd));
    chk({tag, " done_alu"}, alu_result_out, a);
    chk({tag, " done_memtoreg"}, 32'(MemToReg_out), 32'(m2r));
    if (!tout) chk({tag, " done_rdata"}, mem_read_data_out, mw ? 32'h0 : m_load(f3, a, rdata));
    @(negedge clk);
    dmem_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    bit v, mr, mw;
    int kind;

    rst = 1'b1;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    set_in(1'b0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset req", 32'(dmem_req), 32'h0);
    chk("reset addr", dmem_addr, 32'h0);
    chk("reset wstrb", 32'(dmem_wstrb), 32'h0);
    chk("reset wdata", dmem_wdata, 32'h0);
    chk("reset stall", 32'(mem_stall), 32'h0);
    chk("reset regwrite", 32'(RegWrite_out), 32'h0);
    chk("reset err", 32'(access_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_alu("alu_1234", 1'b1, 32'h1234, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    run_mem("lb_103", 32'h103, 32'h0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 32'h80FF_FF00, 2);
    run_mem("sh_202", 32'h202, 32'h0000_ABCD, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 32'h0, 3);
    run_mem("sw_rw_both", 32'h40C, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 32'h0, 1);
    run_mem("lhu_ack1", 32'h612, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 3'b101, 32'h9ABC_1234, 1);
    run_bad("lw_301", 32'h301, 1'b1, 1'b0, 3'b010);
    run_bad("sh_odd", 32'h203, 1'b0, 1'b1, 3'b001);
    run_bad("ld_f3_011", 32'h200, 1'b1, 1'b0, 3'b011);
    run_bad("st_f3_100", 32'h200, 1'b0, 1'b1, 3'b100);
    run_mem("lw_timeout", 32'h500, 32'h0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0, 0);

    // Stray ack while idle must not start anything.
    dmem_ack = 1'b1;
    run_alu("late_ack", 1'b1, 32'h55AA, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    dmem_ack = 1'b0;
    #1;
    chk("late_ack noreq", 32'(dmem_req), 32'h0);
    @(negedge clk);

    // Reset in the middle of REQ.
    set_in(1'b1, 32'h400, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010);
    @(negedge clk);
    #1;
    chk("rst_req pre", 32'(dmem_req), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_req drop", 32'(dmem_req), 32'h0);
    chk("rst_req addr", dmem_addr, 32'h0);
    set_in(1'b0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'h0);
    #1;
    chk("rst_req stall", 32'(mem_stall), 32'h0);
    chk("rst_req regwrite", 32'(RegWrite_out), 32'h0);
    chk("rst_req alu", alu_result_out, 32'h0);
    chk("rst_req err", 32'(access_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_alu("post_rst", 1'b1, 32'h0BAD_F00D, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      f3 = 3'($urandom);
      v  = 1'b1;
      mr = 1'b0;
      mw = 1'b0;
      case (kind)
        0: begin v = 1'($urandom); mr = ~v & 1'($urandom); end
        1: mr = 1'b1;
        2: begin mw = 1'b1; mr = 1'($urandom); end
        default: begin mr = 1'($urandom); mw = 1'($urandom); end
      endcase
      if (v && (mr || mw)) begin
        if (m_legal(mw, f3, a))
          run_mem("rnd_mem", a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), mr, mw, f3,
                  $urandom, $urandom_range(1, 4));
        else
          run_bad("rnd_bad", a, mr, mw, f3);
      end else begin
        run_alu("rnd_alu", v, a, 5'($urandom), 1'($urandom), 1'($urandom), mr, mw);
      end
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
